// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: a rising match edge launches a train of up to pNUM_PULSES delayed pulses.
// Registered outputs; O_trigger first rises 1+delay[0] cycles after the edge. No backpressure: edges while busy are only counted.
module pw_trigger_seq #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pNUM_PULSES  = 4,
    parameter int pIDX_WIDTH   = $clog2(pNUM_PULSES)
) (
    input  logic                                trigger_clk,
    input  logic                                reset_n,
    input  logic                                I_arm,
    input  logic                                I_disarm,
    input  logic                                I_continuous,
    input  logic [pIDX_WIDTH-1:0]               I_pulses_m1,
    input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0] I_trigger_delays,
    input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] I_trigger_widths,
    input  logic                                I_match,
    output logic                                O_trigger,
    output logic                                O_armed,
    output logic                                O_busy,
    output logic [pIDX_WIDTH-1:0]               O_pulse_idx,
    output logic                                O_done,
    output logic [7:0]                          O_missed
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DELAY, ST_PULSE} state_t;

    localparam logic [pIDX_WIDTH-1:0] LP_LAST_IDX = pIDX_WIDTH'(pNUM_PULSES - 1);

    state_t                  r_state, w_state_nxt;
    logic                    r_match;
    logic [pDELAY_WIDTH-1:0] r_dcnt, w_dcnt_nxt;
    logic [pWIDTH_WIDTH-1:0] r_wcnt, w_wcnt_nxt;
    logic [pIDX_WIDTH-1:0]   r_idx, w_idx_nxt;
    logic [pIDX_WIDTH-1:0]   r_last, w_last_nxt;
    logic                    r_done, w_done_nxt;
    logic [7:0]              r_missed, w_missed_nxt;

    logic                    w_match_edge;
    logic                    w_busy;
    logic [pDELAY_WIDTH-1:0] w_delay;
    logic [pWIDTH_WIDTH-1:0] w_width;
    logic [pWIDTH_WIDTH-1:0] w_width_last;
    logic [pIDX_WIDTH-1:0]   w_pulses_clamped;

    assign w_match_edge     = I_match & ~r_match;
    assign w_busy           = (r_state == ST_DELAY) || (r_state == ST_PULSE);
    assign w_delay          = I_trigger_delays[int'(r_idx) * pDELAY_WIDTH +: pDELAY_WIDTH];
    assign w_width          = I_trigger_widths[int'(r_idx) * pWIDTH_WIDTH +: pWIDTH_WIDTH];
    // A zero width still produces a one-cycle pulse.
    assign w_width_last     = (w_width == '0) ? '0 : w_width - 1'b1;
    assign w_pulses_clamped = (I_pulses_m1 > LP_LAST_IDX) ? LP_LAST_IDX : I_pulses_m1;

    always_comb begin
        w_state_nxt  = r_state;
        w_dcnt_nxt   = r_dcnt;
        w_wcnt_nxt   = r_wcnt;
        w_idx_nxt    = r_idx;
        w_last_nxt   = r_last;
        w_done_nxt   = 1'b0;
        w_missed_nxt = r_missed;

        case (r_state)
            ST_IDLE: begin
                if (I_arm) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_match_edge) begin
                    w_state_nxt = ST_DELAY;
                    w_idx_nxt   = '0;
                    w_last_nxt  = w_pulses_clamped;
                    w_dcnt_nxt  = '0;
                end
            end
            ST_DELAY: begin
                if (r_dcnt >= w_delay) begin
                    w_state_nxt = ST_PULSE;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_wcnt >= w_width_last) begin
                    if (r_idx >= r_last) begin
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = I_continuous ? ST_ARMED : ST_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = ST_DELAY;
                    end
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle arm or sequence end.
        if (I_disarm) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b0;
        end

        if (w_busy && w_match_edge && (r_missed != 8'hFF)) w_missed_nxt = r_missed + 8'd1;
        if (I_arm) w_missed_nxt = 8'd0;
    end

    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_match  <= 1'b0;
            r_dcnt   <= '0;
            r_wcnt   <= '0;
            r_idx    <= '0;
            r_last   <= '0;
            r_done   <= 1'b0;
            r_missed <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_match  <= I_match;
            r_dcnt   <= w_dcnt_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_idx    <= w_idx_nxt;
            r_last   <= w_last_nxt;
            r_done   <= w_done_nxt;
            r_missed <= w_missed_nxt;
        end
    end

    assign O_trigger   = (r_state == ST_PULSE);
    assign O_armed     = (r_state == ST_ARMED);
    assign O_busy      = w_busy;
    assign O_pulse_idx = r_idx;
    assign O_done      = r_done;
    assign O_missed    = r_missed;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Bench for pw_trigger_seq with 3 pulses, 4-bit delays and 6-bit widths.
module tb_pw_trigger_seq;

    localparam int DW = 4;
    localparam int WW = 6;
    localparam int NP = 3;
    localparam int IW = 2;

    logic             trigger_clk = 1'b0;
    logic             reset_n;
    logic             I_arm = 1'b0;
    logic             I_disarm = 1'b0;
    logic             I_continuous = 1'b0;
    logic [IW-1:0]    I_pulses_m1 = '0;
    logic [NP*DW-1:0] I_trigger_delays = '0;
    logic [NP*WW-1:0] I_trigger_widths = '0;
    logic             I_match = 1'b0;
    logic             O_trigger;
    logic             O_armed;
    logic             O_busy;
    logic [IW-1:0]    O_pulse_idx;
    logic             O_done;
    logic [7:0]       O_missed;

    pw_trigger_seq #(
        .pDELAY_WIDTH(DW),
        .pWIDTH_WIDTH(WW),
        .pNUM_PULSES (NP),
        .pIDX_WIDTH  (IW)
    ) dut (
        .trigger_clk     (trigger_clk),
        .reset_n         (reset_n),
        .I_arm           (I_arm),
        .I_disarm        (I_disarm),
        .I_continuous    (I_continuous),
        .I_pulses_m1     (I_pulses_m1),
        .I_trigger_delays(I_trigger_delays),
        .I_trigger_widths(I_trigger_widths),
        .I_match         (I_match),
        .O_trigger       (O_trigger),
        .O_armed         (O_armed),
        .O_busy          (O_busy),
        .O_pulse_idx     (O_pulse_idx),
        .O_done          (O_done),
        .O_missed        (O_missed)
    );

    always #5 trigger_clk = ~trigger_clk;

    int          checks = 0;
    int          errors = 0;
    logic [DW-1:0] cfg_d [NP];
    logic [WW-1:0] cfg_w [NP];
    logic        trig_log [256];
    int          last_e;

    task automatic tick();
        @(posedge trigger_clk);
        #1;
    endtask

    task automatic do_arm();
        I_arm = 1'b1;
        tick();
        I_arm = 1'b0;
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NP; i++) begin
            I_trigger_delays[i*DW +: DW] = cfg_d[i];
            I_trigger_widths[i*WW +: WW] = cfg_w[i];
        end
    endtask

    // Reference: DUT armed with I_match low beforehand. Pulse schedule is computed
    // arithmetically from the edge cycle k (t=0) and compared cycle by cycle.
    task automatic run_seq(input bit cont, input int pm1, input int match_len);
        int n, e, idx;
        int s [NP];
        int wd [NP];
        bit trig, busy, done, armed;
        logic [5:0] obs, expv;
        logic [IW-1:0] idx_l;
        n = (pm1 > NP - 1) ? NP - 1 : pm1;
        for (int i = 0; i < NP; i++) wd[i] = (cfg_w[i] == 0) ? 1 : int'(cfg_w[i]);
        s[0] = 1 + int'(cfg_d[0]);
        for (int i = 1; i <= n; i++) s[i] = s[i-1] + wd[i-1] + int'(cfg_d[i]) + 1;
        e = s[n] + wd[n];
        last_e = e;
        apply_cfg();
        I_continuous = cont;
        I_pulses_m1  = IW'(pm1);
        I_match      = 1'b1;
        for (int t = 0; t <= e + 1; t++) begin
            tick();
            if (t == match_len - 1) I_match = 1'b0;
            busy  = (t < e);
            done  = (t == e);
            armed = (t >= e) && cont;
            trig  = 1'b0;
            idx   = 0;
            for (int i = 0; i <= n; i++)
                if (t >= s[i] && t < s[i] + wd[i]) trig = 1'b1;
            if (busy)
                for (int i = 1; i <= n; i++)
                    if (t >= s[i-1] + wd[i-1]) idx = i;
            idx_l = IW'(idx);
            expv  = {trig, done, busy, armed, idx_l};
            obs   = {O_trigger, O_done, O_busy, O_armed, O_pulse_idx};
            trig_log[t] = O_trigger;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL seq t=%0d {trig,done,busy,armed,idx} got=%b exp=%b", t, obs, expv);
            end
        end
        I_match = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({O_trigger, O_armed, O_busy, O_pulse_idx, O_done, O_missed} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {O_trigger, O_armed, O_busy, O_pulse_idx, O_done, O_missed});
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (O_armed !== 1'b0 || O_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle armed=%b busy=%b exp 0 0", O_armed, O_busy);
        end
    endtask

    task automatic test_single();
        cfg_d[0] = 4'd3; cfg_w[0] = 6'd5;
        cfg_d[1] = 4'd0; cfg_w[1] = 6'd0;
        cfg_d[2] = 4'd0; cfg_w[2] = 6'd0;
        do_arm();
        checks++;
        if (O_armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_latency armed=%b exp 1", O_armed);
        end
        run_seq(1'b0, 0, 10);
        checks++;
        if (O_armed !== 1'b0) begin
            errors++;
            $display("FAIL single_idle armed=%b exp 0", O_armed);
        end
    endtask

    task automatic test_multi();
        logic [10:0] pat;
        logic [10:0] got;
        pat = 11'b01011100010;
        cfg_d[0] = 4'd0; cfg_w[0] = 6'd1;
        cfg_d[1] = 4'd2; cfg_w[1] = 6'd3;
        cfg_d[2] = 4'd0; cfg_w[2] = 6'd0;
        do_arm();
        run_seq(1'b0, 2, 2);
        for (int t = 0; t < 11; t++) got[t] = trig_log[t];
        checks++;
        if (got !== pat || last_e != 10) begin
            errors++;
            $display("FAIL multi_pattern got=%b end=%0d exp=%b end=10", got, last_e, pat);
        end
    endtask

    task automatic test_missed();
        bit seen_done;
        cfg_d[0] = 4'd0; cfg_w[0] = 6'd20;
        apply_cfg();
        I_continuous = 1'b1;
        I_pulses_m1  = '0;
        do_arm();
        I_match = 1'b1; tick(); I_match = 1'b0;
        tick(); tick(); tick();
        I_match = 1'b1; tick(); I_match = 1'b0;
        tick();
        checks++;
        if (O_missed !== 8'd1 || O_busy !== 1'b1) begin
            errors++;
            $display("FAIL missed_count got=%0d busy=%b exp=1 busy=1", O_missed, O_busy);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            if (O_done) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done || O_armed !== 1'b1) begin
            errors++;
            $display("FAIL cont_done seen=%b armed=%b exp 1 1", seen_done, O_armed);
        end
        I_match = 1'b1; tick(); I_match = 1'b0;
        checks++;
        if (O_busy !== 1'b1 || O_missed !== 8'd1) begin
            errors++;
            $display("FAIL rearm_accept busy=%b missed=%0d exp busy=1 missed=1", O_busy, O_missed);
        end
        do_arm();
        checks++;
        if (O_missed !== 8'd0 || O_busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_clears_missed missed=%0d busy=%b exp 0 1", O_missed, O_busy);
        end
        I_disarm = 1'b1; tick(); I_disarm = 1'b0;
    endtask

    task automatic test_disarm();
        bit bad;
        cfg_d[0] = 4'd1; cfg_w[0] = 6'd10;
        cfg_d[1] = 4'd1; cfg_w[1] = 6'd10;
        apply_cfg();
        I_continuous = 1'b0;
        I_pulses_m1  = 2'd1;
        do_arm();
        I_match = 1'b1; tick(); I_match = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (O_trigger !== 1'b1) begin
            errors++;
            $display("FAIL disarm_setup trig=%b exp 1", O_trigger);
        end
        I_disarm = 1'b1; tick(); I_disarm = 1'b0;
        checks++;
        if ({O_trigger, O_busy, O_armed, O_done, O_pulse_idx} !== '0) begin
            errors++;
            $display("FAIL disarm_now got=%b exp=0", {O_trigger, O_busy, O_armed, O_done, O_pulse_idx});
        end
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (O_done || O_trigger) bad = 1'b1;
        end
        I_match = 1'b1; tick(); I_match = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (O_trigger || O_busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL disarm_quiet activity=1 exp 0");
        end
        I_arm = 1'b1; I_disarm = 1'b1; tick(); I_arm = 1'b0; I_disarm = 1'b0;
        checks++;
        if (O_armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_disarm_same armed=%b exp 0", O_armed);
        end
    endtask

    task automatic test_async_reset();
        bit bad;
        cfg_d[0] = 4'd15; cfg_w[0] = 6'd2;
        apply_cfg();
        I_continuous = 1'b0;
        I_pulses_m1  = '0;
        do_arm();
        I_match = 1'b1; tick(); I_match = 1'b0;
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({O_trigger, O_armed, O_busy, O_pulse_idx, O_done, O_missed} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0", {O_trigger, O_armed, O_busy, O_pulse_idx, O_done, O_missed});
        end
        #2 reset_n = 1'b1;
        I_match = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 3) I_match = 1'b0;
            if (i == 6) I_match = 1'b1;
            if (O_armed || O_busy || O_trigger) bad = 1'b1;
        end
        I_match = 1'b0;
        tick();
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_idle activity=1 exp 0");
        end
    endtask

    task automatic test_clamp();
        int rises, low;
        bit prev;
        for (int i = 0; i < NP; i++) begin
            cfg_d[i] = 4'hF;
            cfg_w[i] = WW'($urandom_range(1, 4));
        end
        do_arm();
        run_seq(1'b0, 3, 1);
        rises = 0; low = 0; prev = 1'b0;
        for (int t = 0; t <= last_e; t++) begin
            if (trig_log[t]) begin
                if (!prev) begin
                    if (rises > 0) begin
                        checks++;
                        if (low != 16) begin
                            errors++;
                            $display("FAIL clamp_gap pulse=%0d got=%0d exp=16", rises, low);
                        end
                    end
                    rises++;
                end
                low = 0;
            end else begin
                low++;
            end
            prev = trig_log[t];
        end
        checks++;
        if (rises != NP) begin
            errors++;
            $display("FAIL clamp_count got=%0d exp=%0d", rises, NP);
        end
    endtask

    task automatic test_random();
        bit armed_m;
        bit cont;
        armed_m = 1'b0;
        for (int it = 0; it < 25; it++) begin
            cont = 1'($urandom_range(0, 1));
            for (int i = 0; i < NP; i++) begin
                cfg_d[i] = DW'($urandom_range(0, 15));
                cfg_w[i] = WW'($urandom_range(0, 7));
            end
            if (!armed_m) do_arm();
            run_seq(cont, int'($urandom_range(0, 3)), int'($urandom_range(1, 30)));
            armed_m = cont;
        end
        I_disarm = 1'b1; tick(); I_disarm = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            cfg_d[i] = '0;
            cfg_w[i] = '0;
        end
        test_reset();
        test_single();
        test_multi();
        test_missed();
        test_disarm();
        test_async_reset();
        test_clamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
